// File: rtl/rdc_pkg.sv
// Shared types and defaults for reload_down_counter: FSM state encoding,
// mode constants and default widths.
package rdc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } rdc_state_t;

    localparam logic MODE_ONESHOT = 1'b0;
    localparam logic MODE_RELOAD  = 1'b1;

    localparam int DEFAULT_WIDTH      = 9;
    localparam int DEFAULT_PRESCALE_W = 4;

endpackage : rdc_pkg

// File: rtl/rdc_prescaler.sv
// Enable prescaler for reload_down_counter: emits tick once every prescale+1
// enabled cycles; clear restarts the interval.
module rdc_prescaler #(
    parameter int PRESCALE_W = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  clear,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  tick
);

    logic [PRESCALE_W-1:0] pre_cnt_q;
    logic [PRESCALE_W-1:0] pre_cnt_d;

    // >= rather than == so that lowering prescale mid-interval ticks at once
    assign tick = en && (pre_cnt_q >= prescale);

    always_comb begin
        pre_cnt_d = pre_cnt_q;
        if (clear || tick) begin
            pre_cnt_d = '0;
        end else if (en) begin
            pre_cnt_d = pre_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt_q <= '0;
        end else begin
            pre_cnt_q <= pre_cnt_d;
        end
    end

endmodule : rdc_prescaler

// File: rtl/reload_down_counter.sv
// Loadable down counter with one-shot / auto-reload modes and a terminal-count
// pulse. The prescaler is built in only when RELOAD_DOWN_COUNTER_PRESCALE_EN is defined.
module reload_down_counter
    import rdc_pkg::*;
#(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter int PRESCALE_W = DEFAULT_PRESCALE_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  load,
    input  logic [WIDTH-1:0]      load_value,
    input  logic [WIDTH-1:0]      reload_value,
    input  logic                  mode,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic [WIDTH-1:0]      count,
    output logic                  tc,
    output logic                  done,
    output logic                  running
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    rdc_state_t       state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_q, tc_d;
    logic             done_q, done_d;
    logic             tick;

`ifdef RELOAD_DOWN_COUNTER_PRESCALE_EN
    rdc_prescaler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_prescaler (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .clear    (load),
        .prescale (prescale),
        .tick     (tick)
    );
`else
    logic unused_prescale;
    assign unused_prescale = ^prescale;
    assign tick            = en;
`endif

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        tc_d    = 1'b0;
        done_d  = done_q;

        if (load) begin
            count_d = load_value;
            if (load_value != '0) begin
                state_d = RUN;
                done_d  = 1'b0;
            end else begin
                state_d = DONE;
                done_d  = 1'b1;
            end
        end else if (tick && (state_q == RUN)) begin
            if (count_q > ONE) begin
                count_d = count_q - ONE;
            end else if (mode == MODE_ONESHOT) begin
                count_d = '0;
                tc_d    = 1'b1;
                done_d  = 1'b1;
                state_d = DONE;
            end else begin
                // mode and reload_value only matter at this terminal tick
                tc_d = 1'b1;
                if (reload_value != '0) begin
                    count_d = reload_value;
                end else begin
                    count_d = '0;
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            count_q <= '0;
            tc_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            tc_q    <= tc_d;
            done_q  <= done_d;
        end
    end

    assign count   = count_q;
    assign tc      = tc_q;
    assign done    = done_q;
    assign running = (state_q == RUN);

endmodule : reload_down_counter

// File: tb/tb_reload_down_counter.sv
// Directed self-checking bench for reload_down_counter; prescaler cases run
// only when RELOAD_DOWN_COUNTER_PRESCALE_EN is defined.
module tb_reload_down_counter;

    localparam int WIDTH      = 9;
    localparam int PRESCALE_W = 4;

    logic                  clk;
    logic                  rst_n;
    logic                  en;
    logic                  load;
    logic [WIDTH-1:0]      load_value;
    logic [WIDTH-1:0]      reload_value;
    logic                  mode;
    logic [PRESCALE_W-1:0] prescale;
    logic [WIDTH-1:0]      count;
    logic                  tc;
    logic                  done;
    logic                  running;

    int errors = 0;
    int checks = 0;

    reload_down_counter #(
        .WIDTH      (WIDTH),
        .PRESCALE_W (PRESCALE_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .load         (load),
        .load_value   (load_value),
        .reload_value (reload_value),
        .mode         (mode),
        .prescale     (prescale),
        .count        (count),
        .tc           (tc),
        .done         (done),
        .running      (running)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end else begin
            $display("ok   %s: %0d", tag, obs);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input int c, input int t, input int d, input int r);
        check({tag, ".count"},   32'(count),   32'(c));
        check({tag, ".tc"},      32'(tc),      32'(t));
        check({tag, ".done"},    32'(done),    32'(d));
        check({tag, ".running"}, 32'(running), 32'(r));
    endtask

    task automatic do_load(input int v);
        load_value = WIDTH'(v);
        load       = 1'b1;
        step();
        load       = 1'b0;
    endtask

    // auto-reload expected sequence after load_value=2, reload_value=4
    int ar_count [7] = '{2, 1, 4, 3, 2, 1, 4};
    int ar_tc    [7] = '{0, 0, 1, 0, 0, 0, 1};

    initial begin
        rst_n        = 1'b0;
        en           = 1'b0;
        load         = 1'b0;
        load_value   = '0;
        reload_value = '0;
        mode         = 1'b0;
        prescale     = '0;
        step();
        step();
        check_all("reset", 0, 0, 0, 0);
        rst_n = 1'b1;
        en    = 1'b1;
        step();
        check_all("idle_no_load", 0, 0, 0, 0);

        // one-shot 3,2,1,0
        mode = 1'b0;
        do_load(3);
        check_all("os0", 3, 0, 0, 1);
        step(); check_all("os1", 2, 0, 0, 1);
        step(); check_all("os2", 1, 0, 0, 1);
        step(); check_all("os3", 0, 1, 1, 0);
        step(); check_all("os4", 0, 0, 1, 0);

        // auto-reload 2,1,4,3,2,1,4
        mode         = 1'b1;
        reload_value = 9'd4;
        do_load(2);
        for (int i = 0; i < 7; i++) begin
            if (i > 0) step();
            check_all($sformatf("ar%0d", i), ar_count[i], ar_tc[i], 0, 1);
        end
        step(); check_all("ar7", 3, 0, 0, 1);
        step(); check_all("ar8", 2, 0, 0, 1);
        step(); check_all("ar9", 1, 0, 0, 1);

        // load on the same edge as a terminal tick wins
        do_load(7);
        check_all("prio", 7, 0, 0, 1);

        // load of zero
        do_load(0);
        check_all("zero_load", 0, 0, 1, 0);
        step(); check_all("zero_hold", 0, 0, 1, 0);

        // auto-reload with reload_value 0 ends in DONE
        mode         = 1'b1;
        reload_value = 9'd0;
        do_load(1);
        check_all("rz0", 1, 0, 0, 1);
        step(); check_all("rz1", 0, 1, 1, 0);
        step(); check_all("rz2", 0, 0, 1, 0);

        // mode/reload changed mid-run take effect only at terminal tick
        mode = 1'b0;
        do_load(2);
        check_all("mc0", 2, 0, 0, 1);
        mode         = 1'b1;
        reload_value = 9'd5;
        step(); check_all("mc1", 1, 0, 0, 1);
        step(); check_all("mc2", 5, 1, 0, 1);

        // en low freezes count; tc still clears after one cycle
        reload_value = 9'd2;
        do_load(1);
        check_all("en0", 1, 0, 0, 1);
        step(); check_all("en1", 2, 1, 0, 1);
        en = 1'b0;
        step(); check_all("en2", 2, 0, 0, 1);
        step(); step();
        check_all("en3", 2, 0, 0, 1);
        en = 1'b1;
        step(); check_all("en4", 1, 0, 0, 1);

`ifdef RELOAD_DOWN_COUNTER_PRESCALE_EN
        // prescale=2: decrement every third enabled cycle; en gap freezes pre_cnt
        prescale = 4'd2;
        mode     = 1'b0;
        do_load(2);
        check_all("ps0", 2, 0, 0, 1);
        step(); check_all("ps1", 2, 0, 0, 1);
        step(); check_all("ps2", 2, 0, 0, 1);
        step(); check_all("ps3", 1, 0, 0, 1);
        step(); check_all("ps4", 1, 0, 0, 1);
        en = 1'b0;
        for (int i = 0; i < 5; i++) step();
        check_all("ps_frozen", 1, 0, 0, 1);
        en = 1'b1;
        step(); check_all("ps5", 1, 0, 0, 1);
        step(); check_all("ps6", 0, 1, 1, 0);
        prescale = 4'd0;
`endif

        // asynchronous reset mid-run at count 5
        mode = 1'b0;
        do_load(8);
        step(); step(); step();
        check_all("pre_rst", 5, 0, 0, 1);
        #1 rst_n = 1'b0;
        #1 check_all("async_rst", 0, 0, 0, 0);
        #1 rst_n = 1'b1;
        step(); step();
        check_all("post_rst", 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_reload_down_counter
